// File: rtl/cr16_loader_pkg.sv
// rtl/cr16_loader_pkg.sv - shared state types and frame constants for the CR16 UART loader
package cr16_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  // sync byte plus the two length bytes
  localparam int         HEADER_LEN = 3;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 2-flop input synchroniser and centre sampling
module uart_rx
  import cr16_loader_pkg::*;
#(
  parameter int P_DIVISOR = 434
) (
  input  logic       I_CLK,
  input  logic       I_NRESET,
  input  logic       I_RX,
  output logic [7:0] O_DATA,
  output logic       O_VALID,
  output logic       O_FRAME_ERROR
);

  localparam int HALF = P_DIVISOR / 2;

  rx_state_t   state, next_state;
  logic        rx_meta, rx_sync, rx_prev;
  logic [15:0] tick_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        half_tick, bit_tick;

  assign half_tick = (tick_cnt == 16'(HALF - 1));
  assign bit_tick  = (tick_cnt == 16'(P_DIVISOR - 1));

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
    end else begin
      rx_meta <= I_RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state   <= next_state;
    end
  end

  // a start needs a falling edge, so a line held low after a bad stop bit is not re-read
  always_comb begin
    next_state = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) next_state = RX_START;
      RX_START: if (half_tick) next_state = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx == 3'd7) next_state = RX_STOP;
      RX_STOP:  if (bit_tick) next_state = RX_IDLE;
      default:  next_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      if (state == RX_IDLE || state != next_state || (state == RX_DATA && bit_tick))
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 16'd1;
      if (state == RX_START)
        bit_idx <= '0;
      else if (state == RX_DATA && bit_tick) begin
        shift   <= {rx_sync, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    O_DATA        = shift;
    O_VALID       = (state == RX_STOP) && bit_tick && rx_sync;
    O_FRAME_ERROR = (state == RX_STOP) && bit_tick && !rx_sync;
  end

endmodule

// File: rtl/cr16_uart_loader.sv
// rtl/cr16_uart_loader.sv - UART frame loader writing 16-bit words to BRAM and holding the CPU in reset
// Optional checksum verification: define CR16_LOADER_CHECKSUM_EN.
module cr16_uart_loader
  import cr16_loader_pkg::*;
#(
  parameter int P_CLK_FREQ_HZ    = 50_000_000,
  parameter int P_BAUD_RATE      = 115_200,
  parameter int P_ADDRESS_WIDTH  = 10,
  parameter int P_TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,
  input  logic                       I_UART_RX,
  output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
  output logic [15:0]                O_MEM_DATA,
  output logic                       O_MEM_WRITE_ENABLE,
  output logic                       O_CPU_NRESET,
  output logic                       O_DONE,
  output logic                       O_ERROR
);

  localparam int          DIVISOR   = P_CLK_FREQ_HZ / P_BAUD_RATE;
  localparam logic [16:0] MAX_WORDS = 17'(1) << P_ADDRESS_WIDTH;

  loader_state_t state, next_state;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_ferr;
  logic [7:0]    len_hi, data_hi;
  logic [15:0]   length;
  logic [16:0]   word_cnt;
  logic [31:0]   idle_cnt;
  logic          active, timeout, last_word, frame_start;
  logic          cpu_nreset_d, done_d, error_d;
`ifdef CR16_LOADER_CHECKSUM_EN
  logic [7:0]    checksum;
`endif

  uart_rx #(
    .P_DIVISOR(DIVISOR)
  ) u_uart_rx (
    .I_CLK         (I_CLK),
    .I_NRESET      (I_NRESET),
    .I_RX          (I_UART_RX),
    .O_DATA        (rx_data),
    .O_VALID       (rx_valid),
    .O_FRAME_ERROR (rx_ferr)
  );

  assign active      = (state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK});
  assign timeout     = active && !rx_valid && (idle_cnt >= 32'(P_TIMEOUT_CYCLES - 1));
  assign last_word   = ((word_cnt + 17'd1) == {1'b0, length});
  assign frame_start = (next_state == LEN_HI) && (state != LEN_HI);

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state        <= IDLE;
      O_CPU_NRESET <= 1'b0;
      O_DONE       <= 1'b0;
      O_ERROR      <= 1'b0;
    end else begin
      state        <= next_state;
      O_CPU_NRESET <= cpu_nreset_d;
      O_DONE       <= done_d;
      O_ERROR      <= error_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (rx_valid && rx_data == SYNC_BYTE) next_state = LEN_HI;
      end
      default: begin
        if (rx_ferr || timeout)
          next_state = ERROR;
        else if (rx_valid) begin
          case (state)
            LEN_HI:  next_state = LEN_LO;
            LEN_LO: begin
              if ({1'b0, len_hi, rx_data} > MAX_WORDS) next_state = ERROR;
              else if ({len_hi, rx_data} == 16'd0)     next_state = CHECK;
              else                                     next_state = DATA_HI;
            end
            DATA_HI: next_state = DATA_LO;
            DATA_LO: next_state = last_word ? CHECK : DATA_HI;
`ifdef CR16_LOADER_CHECKSUM_EN
            CHECK:   next_state = (rx_data == checksum) ? DONE : ERROR;
`else
            CHECK:   next_state = DONE;
`endif
            default: next_state = state;
          endcase
        end
      end
    endcase
  end

  // status flags are registered from the next state so they change with the state itself
  always_comb begin
    cpu_nreset_d = (next_state == IDLE) || (next_state == DONE);
    done_d       = (next_state == DONE);
    error_d      = (next_state == ERROR);
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      len_hi             <= '0;
      data_hi            <= '0;
      length             <= '0;
      word_cnt           <= '0;
      idle_cnt           <= '0;
      O_MEM_ADDRESS      <= '0;
      O_MEM_DATA         <= '0;
      O_MEM_WRITE_ENABLE <= 1'b0;
`ifdef CR16_LOADER_CHECKSUM_EN
      checksum           <= '0;
`endif
    end else begin
      O_MEM_WRITE_ENABLE <= 1'b0;
      idle_cnt <= (!active || rx_valid) ? 32'd0 : idle_cnt + 32'd1;
      if (O_MEM_WRITE_ENABLE && O_MEM_ADDRESS != '1)
        O_MEM_ADDRESS <= O_MEM_ADDRESS + P_ADDRESS_WIDTH'(1);
      if (frame_start) begin
        word_cnt      <= '0;
        O_MEM_ADDRESS <= '0;
`ifdef CR16_LOADER_CHECKSUM_EN
        checksum      <= '0;
`endif
      end
      if (rx_valid) begin
        case (state)
          LEN_HI:  len_hi  <= rx_data;
          LEN_LO:  length  <= {len_hi, rx_data};
          DATA_HI: data_hi <= rx_data;
          DATA_LO: begin
            O_MEM_DATA         <= {data_hi, rx_data};
            O_MEM_WRITE_ENABLE <= 1'b1;
            word_cnt           <= word_cnt + 17'd1;
          end
          default: ;
        endcase
`ifdef CR16_LOADER_CHECKSUM_EN
        if (state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO})
          checksum <= checksum ^ rx_data;
`endif
      end
    end
  end

endmodule
